// File: rtl/bshift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter (bshift_pipe).
// Operation encoding, the fill-bit rule and the stage-count helper live here.
package bshift_pkg;

    localparam int unsigned OP_W = 3;

    // Values 5..7 are reserved and make every stage pass its data through.
    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // Bit shifted in from the top on right shifts.
    function automatic logic fill_bit(input shift_op_e op, input logic sign);
        return (op == OP_SRA) ? sign : 1'b0;
    endfunction

    function automatic int unsigned popcount(input int unsigned mask, input int unsigned bits);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            n += (mask >> i) & 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bshift_stage.sv
// One binary-weighted stage of the barrel shifter: a fixed SHAMT-bit shift for
// all ops plus an optional register slot with valid/ready. Carry under BSHIFT_FLAGS_EN.
module bshift_stage
    import bshift_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHAMT = 1,
    parameter bit          REG   = 1'b0,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_shamt,
    input  shift_op_e        up_op,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             up_sign,
`ifdef BSHIFT_FLAGS_EN
    input  logic             up_carry,
    output logic             dn_carry,
`endif
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [SHW-1:0]   dn_shamt,
    output shift_op_e        dn_op,
    output logic [TAG_W-1:0] dn_tag,
    output logic             dn_sign
);

    localparam int unsigned BIT = $clog2(SHAMT);

    logic [WIDTH-1:0] shifted;
    logic             fill;

    always_comb begin
        shifted = up_data;
        fill    = fill_bit(up_op, up_sign);
        if (up_shamt[BIT]) begin
            case (up_op)
                OP_SLL:         shifted = {up_data[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
                OP_ROL:         shifted = {up_data[WIDTH-1-SHAMT:0], up_data[WIDTH-1:WIDTH-SHAMT]};
                OP_SRL, OP_SRA: shifted = {{SHAMT{fill}}, up_data[WIDTH-1:SHAMT]};
                OP_ROR:         shifted = {up_data[SHAMT-1:0], up_data[WIDTH-1:SHAMT]};
                default:        shifted = up_data;
            endcase
        end
    end

`ifdef BSHIFT_FLAGS_EN
    // Later active stages overwrite the carry, so the highest active stage wins.
    logic carry_next;

    always_comb begin
        carry_next = up_carry;
        if (up_shamt[BIT]) begin
            case (up_op)
                OP_SLL, OP_ROL:         carry_next = up_data[WIDTH-SHAMT];
                OP_SRL, OP_SRA, OP_ROR: carry_next = up_data[SHAMT-1];
                default:                carry_next = up_carry;
            endcase
        end
    end
`endif

    generate
        if (REG) begin : g_reg
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;
            logic [SHW-1:0]   shamt_reg;
            shift_op_e        op_reg;
            logic [TAG_W-1:0] tag_reg;
            logic             sign_reg;

            assign up_ready = !valid_reg || dn_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    shamt_reg <= '0;
                    op_reg    <= OP_SLL;
                    tag_reg   <= '0;
                    sign_reg  <= 1'b0;
                end else if (up_valid && up_ready) begin
                    valid_reg <= 1'b1;
                    data_reg  <= shifted;
                    shamt_reg <= up_shamt;
                    op_reg    <= up_op;
                    tag_reg   <= up_tag;
                    sign_reg  <= up_sign;
                end else if (dn_ready) begin
                    valid_reg <= 1'b0;
                end
            end

            assign dn_valid = valid_reg;
            assign dn_data  = data_reg;
            assign dn_shamt = shamt_reg;
            assign dn_op    = op_reg;
            assign dn_tag   = tag_reg;
            assign dn_sign  = sign_reg;

`ifdef BSHIFT_FLAGS_EN
            logic carry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    carry_reg <= 1'b0;
                end else if (up_valid && up_ready) begin
                    carry_reg <= carry_next;
                end
            end

            assign dn_carry = carry_reg;
`endif
        end else begin : g_comb
            assign up_ready = dn_ready;
            assign dn_valid = up_valid;
            assign dn_data  = shifted;
            assign dn_shamt = up_shamt;
            assign dn_op    = up_op;
            assign dn_tag   = up_tag;
            assign dn_sign  = up_sign;
`ifdef BSHIFT_FLAGS_EN
            assign dn_carry = carry_next;
`endif
        end
    endgenerate

endmodule

// File: rtl/bshift_pipe.sv
// Pipelined multi-mode barrel shifter: log2(WIDTH) stages, PIPE_MASK bit k registers
// stage k, latency = popcount(PIPE_MASK). Define BSHIFT_FLAGS_EN for out_carry/out_zero.
module bshift_pipe
    import bshift_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned PIPE_MASK = 'b001001,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned SHW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  shift_op_e        in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef BSHIFT_FLAGS_EN
    ,
    output logic             out_carry,
    output logic             out_zero
`endif
);

    localparam int unsigned LATENCY = popcount(PIPE_MASK, SHW);

    genvar gi;

    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            logic             up_valid;
            logic             up_ready;
            logic             dn_valid;
            logic             dn_ready;
            logic [WIDTH-1:0] up_data;
            logic [WIDTH-1:0] dn_data;
            logic [SHW-1:0]   up_shamt;
            logic [SHW-1:0]   dn_shamt;
            shift_op_e        up_op;
            shift_op_e        dn_op;
            logic [TAG_W-1:0] up_tag;
            logic [TAG_W-1:0] dn_tag;
            logic             up_sign;
            logic             dn_sign;
`ifdef BSHIFT_FLAGS_EN
            logic             up_carry;
            logic             dn_carry;
`endif

            if (gi == 0) begin : g_head
                assign up_valid = in_valid;
                assign up_data  = in_data;
                assign up_shamt = in_shamt;
                assign up_op    = in_op;
                assign up_tag   = in_tag;
                // Sign is captured once so SRA fill survives any number of stages.
                assign up_sign  = in_data[WIDTH-1];
`ifdef BSHIFT_FLAGS_EN
                assign up_carry = 1'b0;
`endif
            end else begin : g_link
                assign up_valid = g_stage[gi-1].dn_valid;
                assign up_data  = g_stage[gi-1].dn_data;
                assign up_shamt = g_stage[gi-1].dn_shamt;
                assign up_op    = g_stage[gi-1].dn_op;
                assign up_tag   = g_stage[gi-1].dn_tag;
                assign up_sign  = g_stage[gi-1].dn_sign;
`ifdef BSHIFT_FLAGS_EN
                assign up_carry = g_stage[gi-1].dn_carry;
`endif
            end

            if (gi == SHW - 1) begin : g_tail
                assign dn_ready = out_ready;
            end else begin : g_next
                assign dn_ready = g_stage[gi+1].up_ready;
            end

            bshift_stage #(
                .WIDTH (WIDTH),
                .SHAMT (1 << gi),
                .REG   (((PIPE_MASK >> gi) & 1) != 0),
                .SHW   (SHW),
                .TAG_W (TAG_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (up_valid),
                .up_ready (up_ready),
                .up_data  (up_data),
                .up_shamt (up_shamt),
                .up_op    (up_op),
                .up_tag   (up_tag),
                .up_sign  (up_sign),
`ifdef BSHIFT_FLAGS_EN
                .up_carry (up_carry),
                .dn_carry (dn_carry),
`endif
                .dn_valid (dn_valid),
                .dn_ready (dn_ready),
                .dn_data  (dn_data),
                .dn_shamt (dn_shamt),
                .dn_op    (dn_op),
                .dn_tag   (dn_tag),
                .dn_sign  (dn_sign)
            );
        end
    endgenerate

    assign in_ready  = g_stage[0].up_ready;
    assign out_valid = g_stage[SHW-1].dn_valid;
    assign out_data  = g_stage[SHW-1].dn_data;
    assign out_tag   = g_stage[SHW-1].dn_tag;

`ifdef BSHIFT_FLAGS_EN
    assign out_carry = g_stage[SHW-1].dn_carry;
    assign out_zero  = (out_data == '0);
`endif

    // Sideband that only steers stages has no consumer after the last one.
    logic unused_tail;
    assign unused_tail = ^{g_stage[SHW-1].dn_shamt, g_stage[SHW-1].dn_op,
                           g_stage[SHW-1].dn_sign, LATENCY[0]};

endmodule

// File: doc/bshift_pipe.md
Name: bshift_pipe

Overview:
- Parametrised, pipelined, multi-mode barrel shifter for the ALU core.
- Five operations: logical left, logical right, arithmetic right, rotate left and rotate right.
- Built from log2(WIDTH) binary-weighted stages, with an optional register after each stage.
- Valid/ready handshake on both sides, with per-stage bubble collapsing.

Parameters:
- WIDTH, 64, data width; power of 2, at least 8.
- PIPE_MASK, 6'b001001, bit k=1 puts a register after stage k; width SHW=$clog2(WIDTH); latency L = popcount(PIPE_MASK).
- TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept the input beat.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_op  in  3  operation, type shift_op_e.
- in_tag  in  TAG_W  opaque tag, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_carry  out  1  last bit shifted out; present only with BSHIFT_FLAGS_EN.
- out_zero  out  1  out_data == 0; present only with BSHIFT_FLAGS_EN.

Behaviour:
- Reset is asynchronous and active-high.
  - All stage valid bits clear to 0, so out_valid=0.
  - Data, tag and flag registers clear to 0.
  - in_ready=1 after reset is released.
- Op encoding:
  - 0 SLL: zero fill.
  - 1 SRL: zero fill.
  - 2 SRA: fill with in_data[WIDTH-1].
  - 3 ROL.
  - 4 ROR.
  - 5..7 are reserved and pass the data through unchanged, as if shamt were 0.
- Stages:
  - Stage k shifts by 2^k when in_shamt[k]=1, otherwise passes its input through.
  - Op, the remaining shamt bits, the tag and the SRA sign bit travel with the data.
  - Stages without a register are combinational.
- Latency: exactly L cycles from an accepted input beat to out_valid, when there is no backpressure.
  - L=0: fully combinational; out_valid=in_valid, in_ready=out_ready.
- Handshake:
  - A beat is transferred when valid && ready on either side.
  - Registered slot j has ready_j = !valid_j || ready_{j+1}; the last ready_j is out_ready.
  - in_ready = ready_0.
  - A slot loads when its upstream is valid and ready_j=1; it clears valid when it empties without a refill.
  - Bubbles collapse: a gap in the stream does not stall upstream slots.
  - Full throughput: 1 beat per cycle while out_ready=1.
  - Outputs hold stable while out_valid && !out_ready.
  - Simultaneous accept and drain in the same slot is legal; the new beat replaces the old one.
- Boundary conditions:
  - shamt=0 gives out=in for every op.
  - shamt=WIDTH-1 is the maximum; there are no out-of-range amounts because in_shamt is SHW bits wide.
  - Results keep their input order, and tags stay paired with their data.
- Reset mid-operation: in-flight beats are discarded with no output beat; the tag is not returned.

Optional Feature:
- Macro: BSHIFT_FLAGS_EN.
- With the macro defined:
  - out_carry for SLL/ROL is in_data[WIDTH-shamt].
  - out_carry for SRL/SRA/ROR is in_data[shamt-1].
  - out_carry is 0 when shamt=0 or the op is reserved.
  - out_zero = (out_data==0).
  - The carry is accumulated per stage as the last bit dropped by the highest active stage, and is registered together with the data.
- Without the macro: the out_carry and out_zero ports and their logic are absent.

Decomposition:
- Package bshift_pkg contains:
  - typedef enum logic [2:0] shift_op_e.
  - Constants OP_SLL..OP_ROR.
  - A function for the fill bit.
- Sub-module bshift_stage #(WIDTH, SHAMT, REG) is instantiated by generate, once per k.
  - It holds one 2^k shift across all ops and its optional register slot with the valid/ready logic.

Test Plan (WIDTH=64, PIPE_MASK=6'b001001, so L=2, unless noted):
- SLL with in_data=64'h1, shamt=63, tag=5 -> 2 cycles later out_data=64'h8000_0000_0000_0000, tag=5, carry=0.
- SRA with in_data=64'h8000_0000_0000_0000, shamt=4 -> out=64'hF800_0000_0000_0000; SRL with the same input -> 64'h0800_0000_0000_0000.
- ROR with 64'h0000_0000_0000_00FF, shamt=8 -> 64'hFF00_0000_0000_0000, carry=1; ROL of that result, shamt=8 -> 64'hFF.
- Backpressure: 10 back-to-back beats while out_ready toggles 1,0,0,1… -> no beat lost or duplicated, tags 0..9 in order, outputs stable while stalled; with out_ready=1, one result per cycle.
- Reset asserted while 2 beats are in flight -> out_valid drops immediately, no stale output after release; shamt=0 with op=6 -> out=in.
- Config PIPE_MASK=0 -> out_valid=in_valid in the same cycle; random 1000-beat check against a reference model, also run with PIPE_MASK=6'b111111 (L=6).
